// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. one buffered MDU result,
// with starvation stall and a per-register pending scoreboard for decode interlock.
module wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_wb_wen,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_wb_stall,
    input  logic            i_mdu_valid,
    output logic            o_mdu_ready,
    input  logic [4:0]      i_mdu_rd,
    input  logic [XLEN-1:0] i_mdu_data,
    input  logic            i_issue_vld,
    input  logic [4:0]      i_issue_rd,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic            o_rs1_busy,
    output logic            o_rs2_busy,
    output logic            o_rf_wen,
    output logic [4:0]      o_rf_waddr,
    output logic [XLEN-1:0] o_rf_wdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic            buf_full_q, buf_full_d;
    logic [4:0]      buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     pend_q, pend_d;
    logic            rf_wen_q, rf_wen_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic starve;
    logic wb_idle;
    logic drain;
    logic accept;

    // Stall and ready derive only from registered state.
    assign starve  = buf_full_q && (cnt_q == CNT_MAX);
    assign wb_idle = !i_wb_wen || (i_wb_addr == 5'd0);
    assign drain   = buf_full_q && (starve || wb_idle);
    assign accept  = i_mdu_valid && !buf_full_q;

    assign o_wb_stall  = starve;
    assign o_mdu_ready = !buf_full_q;
    assign o_rs1_busy  = pend_q[i_rs1_addr];
    assign o_rs2_busy  = pend_q[i_rs2_addr];
    assign o_rf_wen    = rf_wen_q;
    assign o_rf_waddr  = rf_waddr_q;
    assign o_rf_wdata  = rf_wdata_q;

    always_comb begin
        buf_full_d = buf_full_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = i_wb_addr;
        rf_wdata_d = i_wb_data;

        if (drain) begin
            buf_full_d         = 1'b0;
            cnt_d              = '0;
            rf_wen_d           = (buf_rd_q != 5'd0);
            rf_waddr_d         = buf_rd_q;
            rf_wdata_d         = buf_data_q;
            pend_d[buf_rd_q]   = 1'b0;
        end else begin
            rf_wen_d = i_wb_wen && (i_wb_addr != 5'd0);
            if (buf_full_q && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (accept) begin
            buf_full_d = 1'b1;
            buf_rd_d   = i_mdu_rd;
            buf_data_d = i_mdu_data;
        end

        // Issue applied after drain so a same-register collision leaves the bit set.
        if (i_issue_vld) begin
            pend_d[i_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_q <= 1'b0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked against a
// queue-based behavioural model of the arbitration rules.
module tb_wb_arbiter;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STARVE = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_wb_wen;
    logic [4:0]      i_wb_addr;
    logic [XLEN-1:0] i_wb_data;
    logic            o_wb_stall;
    logic            i_mdu_valid;
    logic            o_mdu_ready;
    logic [4:0]      i_mdu_rd;
    logic [XLEN-1:0] i_mdu_data;
    logic            i_issue_vld;
    logic [4:0]      i_issue_rd;
    logic [4:0]      i_rs1_addr;
    logic [4:0]      i_rs2_addr;
    logic            o_rs1_busy;
    logic            o_rs2_busy;
    logic            o_rf_wen;
    logic [4:0]      o_rf_waddr;
    logic [XLEN-1:0] o_rf_wdata;

    wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wb_wen(i_wb_wen), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_stall(o_wb_stall),
        .i_mdu_valid(i_mdu_valid), .o_mdu_ready(o_mdu_ready),
        .i_mdu_rd(i_mdu_rd), .i_mdu_data(i_mdu_data),
        .i_issue_vld(i_issue_vld), .i_issue_rd(i_issue_rd),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
        .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } mdu_res_t;

    // Model: waiting MDU results, how long the oldest has waited, outstanding registers.
    mdu_res_t        mq[$];
    int              age;
    bit              pend[32];
    logic            e_wen;
    logic [4:0]      e_addr;
    logic [XLEN-1:0] e_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        age = 0;
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        e_wen  = 1'b0;
        e_addr = '0;
        e_data = '0;
    endtask

    function automatic bit m_stall();
        return (mq.size() == 1) && (age == STARVE);
    endfunction

    // One clock: check state-derived outputs, step model at the edge, check rf outputs.
    task automatic cycle();
        bit stall_now, drain, accept;
        mdu_res_t r;
        #1;
        check("mdu_ready", 32'(o_mdu_ready), 32'(mq.size() == 0));
        check("wb_stall", 32'(o_wb_stall), 32'(m_stall()));
        check("rs1_busy", 32'(o_rs1_busy), 32'(pend[i_rs1_addr]));
        check("rs2_busy", 32'(o_rs2_busy), 32'(pend[i_rs2_addr]));
        stall_now = m_stall();
        drain  = (mq.size() == 1) && (stall_now || !i_wb_wen || (i_wb_addr == 5'd0));
        accept = i_mdu_valid && (mq.size() == 0);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (drain) begin
                r = mq.pop_front();
                e_wen  = (r.rd != 5'd0);
                e_addr = r.rd;
                e_data = r.data;
                age    = 0;
                pend[r.rd] = 1'b0;
            end else begin
                e_wen  = i_wb_wen && (i_wb_addr != 5'd0);
                e_addr = i_wb_addr;
                e_data = i_wb_data;
                if (mq.size() == 1 && age < STARVE) age++;
            end
            if (accept) begin
                r.rd = i_mdu_rd;
                r.data = i_mdu_data;
                mq.push_back(r);
            end
            if (i_issue_vld) pend[i_issue_rd] = 1'b1;
            pend[0] = 1'b0;
        end
        #1;
        check("rf_wen", 32'(o_rf_wen), 32'(e_wen));
        if (e_wen) begin
            check("rf_waddr", 32'(o_rf_waddr), 32'(e_addr));
            check("rf_wdata", o_rf_wdata, e_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_wb_wen = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        i_mdu_valid = 1'b0; i_mdu_rd = '0; i_mdu_data = '0;
        i_issue_vld = 1'b0; i_issue_rd = '0;
        i_rs1_addr = '0; i_rs2_addr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
    endtask

    int stalls;

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);

        // Reset with an MDU result offered: nothing accepted, nothing written.
        rst_n = 1'b0;
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd3; i_mdu_data = 32'h1234_5678;
        model_reset();
        cycle();
        cycle();
        check("reset_ready", 32'(o_mdu_ready), 32'd1);
        check("reset_wen", 32'(o_rf_wen), 32'd0);
        rst_n = 1'b1;
        idle_inputs();
        cycle();

        // Idle drain with scoreboard interlock.
        i_issue_vld = 1'b1; i_issue_rd = 5'd5; i_rs1_addr = 5'd5;
        cycle();
        i_issue_vld = 1'b0;
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd5; i_mdu_data = 32'hDEAD_BEEF;
        check("idle_busy_before", 32'(o_rs1_busy), 32'd1);
        cycle();
        i_mdu_valid = 1'b0;
        cycle();
        check("idle_drain_wen", 32'(o_rf_wen), 32'd1);
        check("idle_drain_addr", 32'(o_rf_waddr), 32'd5);
        check("idle_drain_data", o_rf_wdata, 32'hDEAD_BEEF);
        cycle();
        check("idle_busy_after", 32'(o_rs1_busy), 32'd0);

        // Starvation: continuous pipeline writes to x1 with rd=7 buffered.
        i_wb_wen = 1'b1; i_wb_addr = 5'd1; i_wb_data = 32'hAAAA_0001;
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd7; i_mdu_data = 32'h7777_7777;
        cycle();
        i_mdu_valid = 1'b0;
        stalls = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (o_wb_stall) stalls++;
            cycle();
        end
        check("starve_stall_cycles", 32'(stalls), 32'd1);

        // Back-pressure: a second result waits until the first drains.
        i_wb_addr = 5'd2;
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd3; i_mdu_data = 32'h3333_0000;
        cycle();
        i_mdu_rd = 5'd4; i_mdu_data = 32'h4444_0000;
        check("bp_ready_low", 32'(o_mdu_ready), 32'd0);
        for (int k = 0; k < 8; k++) cycle();
        i_mdu_valid = 1'b0;
        for (int k = 0; k < 7; k++) cycle();

        // x0: pipeline write to x0 frees a drain slot; MDU result to x0 emits nothing.
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd6; i_mdu_data = 32'h6666_0000;
        cycle();
        i_mdu_valid = 1'b0; i_wb_addr = 5'd0;
        cycle();
        i_wb_wen = 1'b0;
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd0; i_mdu_data = 32'h0000_0BAD;
        cycle();
        i_mdu_valid = 1'b0;
        cycle();
        check("x0_no_write", 32'(o_rf_wen), 32'd0);
        cycle();

        // Set/clear collision on rd=9.
        i_wb_wen = 1'b1; i_wb_addr = 5'd2;
        i_issue_vld = 1'b1; i_issue_rd = 5'd9;
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd9; i_mdu_data = 32'h9999_0000;
        cycle();
        i_mdu_valid = 1'b0; i_issue_vld = 1'b0;
        cycle();
        i_wb_wen = 1'b0; i_issue_vld = 1'b1; i_issue_rd = 5'd9; i_rs2_addr = 5'd9;
        cycle();
        i_issue_vld = 1'b0;
        cycle();
        check("collision_pending", 32'(o_rs2_busy), 32'd1);

        // Mid-operation reset discards buffered result and pending bits.
        i_wb_wen = 1'b1; i_wb_addr = 5'd2;
        i_issue_vld = 1'b1; i_issue_rd = 5'd12; i_rs1_addr = 5'd12;
        i_mdu_valid = 1'b1; i_mdu_rd = 5'd12; i_mdu_data = 32'hC0C0_C0C0;
        cycle();
        idle_inputs();
        do_reset();
        for (int k = 0; k < 3; k++) cycle();

        // Random traffic; pipeline inputs held while stalled.
        for (int n = 0; n < 3000; n++) begin
            if (!m_stall()) begin
                i_wb_wen  = ($urandom_range(0, 3) != 0);
                i_wb_addr = 5'($urandom_range(0, 7));
                i_wb_data = $urandom;
            end
            i_mdu_valid = ($urandom_range(0, 2) == 0);
            i_mdu_rd    = 5'($urandom_range(0, 7));
            i_mdu_data  = $urandom;
            i_issue_vld = ($urandom_range(0, 3) == 0);
            i_issue_rd  = 5'($urandom_range(0, 7));
            i_rs1_addr  = 5'($urandom_range(0, 7));
            i_rs2_addr  = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 499) == 0) begin
                idle_inputs();
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
